vga_rect_fill: RTL and testbench
================================

// Module: vga_rect_fill
// PURPOSE
//  MMIO rectangle-fill accelerator for the 160x120 12-bit framebuffer.
//  Sits on the OTTER IOBUS, directly upstream of the VGA framebuffer driver.
//  The CPU programs origin, size and colour; the block emits one framebuffer
//  write per clock (WA/WD/WE) until the rectangle is drawn.
//  The wrapper ORs/muxes FB_* with the CPU single-pixel path. FB_BUSY gives
//  the block priority.
// PARAMETERS
//  BASE_AD   32'h11000180  base MMIO address; registers at +0x0, +0x4, +0x8, +0xC
//  SCREEN_W  160           visible width in pixels (x range 0..SCREEN_W-1)
//  SCREEN_H  120           visible height in pixels (y range 0..SCREEN_H-1)
// PORTS
//  CLK        in   1   system clock (50 MHz CPU clock)
//  RST_N      in   1   asynchronous reset, active-low
//  IO_WR      in   1   IOBUS write strobe
//  IO_ADDR    in   32  IOBUS address
//  IO_DATA    in   32  IOBUS write data
//  IO_RD      out  32  read data; {31'b0,FB_BUSY} when IO_ADDR==BASE_AD+0xC, else 0
//  FB_WA      out  15  framebuffer address {y[6:0],x[7:0]}
//  FB_WD      out  12  framebuffer pixel colour
//  FB_WE      out  1   framebuffer write enable, one pixel per asserted cycle
//  FB_BUSY    out  1   high while the fill is in progress
//  DONE       out  1   one-cycle pulse when a fill completes (or a null fill ends)
// BEHAVIOUR
//  - Reset: asynchronous, all outputs 0, FSM in IDLE, all registers 0.
//    Reset during FILL aborts the fill immediately. No DONE pulse is produced.
//  - Registers (written when IO_WR && IO_ADDR matches):
//    - +0x0 XY: x0=D[7:0], y0=D[22:16]
//    - +0x4 WH: w=D[7:0], h=D[22:16]
//    - +0x8 COLOR: col=D[11:0]. Writing COLOR starts the fill.
//  - Any write to +0x0..+0x8 while FB_BUSY=1 is ignored entirely.
//  - Clip at start:
//    - xe = min(x0+w, SCREEN_W), 9-bit add. ye = min(y0+h, SCREEN_H), 8-bit add.
//    - Null fill when x0>=SCREEN_W, y0>=SCREEN_H, w==0 or h==0.
//  - FSM states:
//    - IDLE: on a COLOR write, go to FILL, or to NULL for a null fill.
//      Load x=x0 and y=y0.
//    - FILL: each cycle assert FB_WE with FB_WA={y,x} and FB_WD=col. Then x++.
//      When x+1==xe: x=x0, y++. When additionally y+1==ye: go to DONE_ST.
//    - NULL: one cycle with FB_WE=0, then go to DONE_ST.
//    - DONE_ST: DONE=1 for one cycle, FB_BUSY=0, back to IDLE.
//      A COLOR write in this cycle is accepted.
//  - Timing:
//    - FB_BUSY rises the cycle after the COLOR write and is high through
//      FILL/NULL.
//    - The first FB_WE is the cycle after the COLOR write.
//    - The fill takes exactly (xe-x0)*(ye-y0) FB_WE cycles, contiguous.
//    - DONE is asserted the cycle after the last FB_WE.
//  - FB_WA/FB_WD are registered outputs and hold their last value when FB_WE=0.
//  - Raster order: row-major, top-left to bottom-right. No pixel is written
//    twice, and no pixel is written outside the clip window.
//  - Simultaneous IO_WR to COLOR on the same cycle that DONE_ST exits: the new
//    fill starts with the XY/WH values currently held.
// CONFIGURATION
//  RECT_OUTLINE_EN
//    - Defined: COLOR D[12] selects outline mode. In outline mode only pixels
//      with x==x0, x==xe-1, y==y0 or y==ye-1 are written.
//    - In outline mode the FSM still traverses every clipped position.
//      FB_WE is low on interior positions.
//    - Clipping decides which edges are drawn: an edge that lies past the
//      screen border is clipped, and the clipped xe-1/ye-1 acts as the edge.
//    - Latency is unchanged: DONE comes (xe-x0)*(ye-y0)+1 cycles after start.
//    - Undefined: D[12] is ignored and every fill is solid.
// TESTING
//  1. XY=(10,5), WH=(3,2), COLOR=0xF00 -> exactly 6 FB_WE cycles starting the
//     cycle after the COLOR write.
//     - WA = {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}; WD=0xF00 on each.
//     - DONE pulses on the next cycle.
//  2. XY=(158,118), WH=(5,5), COLOR=0x0F0 -> clipped to 2x2.
//     - WA = {118,158},{118,159},{119,158},{119,159}.
//     - No write has x>=160 or y>=120.
//  3. WH=(0,7), then COLOR=0x123 -> FB_WE never asserts; FB_BUSY high for 1
//     cycle; DONE pulses 2 cycles after the write.
//  4. During a 40x40 fill, write XY=(0,0) and COLOR=0xFFF -> ignored.
//     - All 1600 writes keep the original colour and origin.
//     - Read of +0xC returns 1 while busy and 0 after DONE.
//  5. Deassert RST_N (drive low) mid-fill (cycle 17 of 100) -> FB_WE, FB_BUSY
//     and DONE go 0 immediately.
//     - After RST_N returns high, no writes occur until a new COLOR write.
//  6. [RECT_OUTLINE_EN] XY=(0,0), WH=(4,3), COLOR=0x1ABC -> 10 writes.
//     - Interior {1,1} and {1,2} are skipped.
//     - DONE arrives 13 cycles after the COLOR write.

Source files
------------

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: MMIO rectangle-fill engine for a 160x120 12-bit framebuffer.
// Optional `RECT_OUTLINE_EN: COLOR bit 12 selects outline-only drawing.
module vga_rect_fill #(
  parameter logic [31:0] BASE_AD  = 32'h11000180,
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IO_WR,
  input  logic [31:0] IO_ADDR,
  input  logic [31:0] IO_DATA,
  output logic [31:0] IO_RD,
  output logic [14:0] FB_WA,
  output logic [11:0] FB_WD,
  output logic        FB_WE,
  output logic        FB_BUSY,
  output logic        DONE
);
  // state   | meaning
  // ST_IDLE | waiting for a COLOR write
  // ST_FILL | one clipped pixel position per cycle
  // ST_NULL | empty rectangle, single dead cycle
  // ST_DONE | DONE pulse; a new COLOR write is accepted here
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_NULL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [8:0] SCR_W = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H = 8'(SCREEN_H);

  logic [1:0]  state_q, state_d;
  logic [7:0]  x0_q, x0_d, w_q, w_d, x_q, x_d;
  logic [6:0]  y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic [8:0]  xe_q, xe_d;
  logic [7:0]  ye_q, ye_d;
  logic [14:0] fb_wa_q, fb_wa_d;
  logic [11:0] fb_wd_q, fb_wd_d;
  logic        fb_we_q, fb_we_d;
  logic        busy, wr_ok, wr_color, null_fill, row_end, last_px, draw;
  logic [8:0]  x_sum, xe_clip;
  logic [7:0]  y_sum, ye_clip;
  logic [7:0]  nx;
  logic [6:0]  ny;
  logic        unused_data;

  assign busy      = (state_q == ST_FILL) || (state_q == ST_NULL);
  assign wr_ok     = IO_WR && !busy;
  assign wr_color  = wr_ok && (IO_ADDR == BASE_AD + 32'h8);

  assign x_sum     = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum     = {1'b0, y0_q} + {1'b0, h_q};
  assign xe_clip   = (x_sum > SCR_W) ? SCR_W : x_sum;
  assign ye_clip   = (y_sum > SCR_H) ? SCR_H : y_sum;
  assign null_fill = ({1'b0, x0_q} >= SCR_W) || ({1'b0, y0_q} >= SCR_H) ||
                     (w_q == 8'd0) || (h_q == 7'd0);

  assign row_end   = (({1'b0, x_q} + 9'd1) == xe_q);
  assign last_px   = row_end && (({1'b0, y_q} + 8'd1) == ye_q);
  assign nx        = row_end ? x0_q : x_q + 8'd1;
  assign ny        = row_end ? y_q + 7'd1 : y_q;

`ifdef RECT_OUTLINE_EN
  logic outline_q, outline_d;
  // Interior positions are still visited so latency matches a solid fill.
  assign draw = !outline_q || (nx == x0_q) || (({1'b0, nx} + 9'd1) == xe_q) ||
                (ny == y0_q) || (({1'b0, ny} + 8'd1) == ye_q);
  assign unused_data = ^{IO_DATA[31:23], IO_DATA[15:13]};
`else
  assign draw = 1'b1;
  assign unused_data = ^{IO_DATA[31:23], IO_DATA[15:12]};
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    fb_we_d = 1'b0;
    fb_wa_d = fb_wa_q;
    fb_wd_d = fb_wd_q;
`ifdef RECT_OUTLINE_EN
    outline_d = outline_q;
`endif
    if (wr_ok && (IO_ADDR == BASE_AD)) begin
      x0_d = IO_DATA[7:0];
      y0_d = IO_DATA[22:16];
    end
    if (wr_ok && (IO_ADDR == BASE_AD + 32'h4)) begin
      w_d = IO_DATA[7:0];
      h_d = IO_DATA[22:16];
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (wr_color) begin
          x_d = x0_q;
          y_d = y0_q;
          if (null_fill) begin
            state_d = ST_NULL;
          end else begin
            state_d = ST_FILL;
            xe_d    = xe_clip;
            ye_d    = ye_clip;
            fb_we_d = 1'b1;
            fb_wa_d = {y0_q, x0_q};
            fb_wd_d = IO_DATA[11:0];
`ifdef RECT_OUTLINE_EN
            outline_d = IO_DATA[12];
`endif
          end
        end
      end
      ST_FILL: begin
        // Output registers carry the pixel after the one currently on the bus.
        if (last_px) begin
          state_d = ST_DONE;
        end else begin
          x_d     = nx;
          y_d     = ny;
          fb_we_d = draw;
          if (draw) fb_wa_d = {ny, nx};
        end
      end
      ST_NULL: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      fb_we_q <= 1'b0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
`ifdef RECT_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      fb_we_q <= fb_we_d;
      fb_wa_q <= fb_wa_d;
      fb_wd_q <= fb_wd_d;
`ifdef RECT_OUTLINE_EN
      outline_q <= outline_d;
`endif
    end
  end

  assign FB_WE   = fb_we_q;
  assign FB_WA   = fb_wa_q;
  assign FB_WD   = fb_wd_q;
  assign FB_BUSY = busy;
  assign DONE    = (state_q == ST_DONE);
  assign IO_RD   = (IO_ADDR == BASE_AD + 32'hC) ? {31'b0, busy} : 32'b0;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: solid, clipped, null, busy-ignore,
// async-reset abort and outline (`RECT_OUTLINE_EN) fills.
module tb_vga_rect_fill;
  localparam logic [31:0] BASE = 32'h11000180;

  logic        CLK;
  logic        RST_N;
  logic        IO_WR;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_DATA;
  logic [31:0] IO_RD;
  logic [14:0] FB_WA;
  logic [11:0] FB_WD;
  logic        FB_WE;
  logic        FB_BUSY;
  logic        DONE;

  int errors = 0;
  int checks = 0;
  int wa_log[$];
  int wd_log[$];
  int exp_wa[$];
  int done_cyc, busy_cnt, first_we;
  logic [31:0] rd_busy, rd_done;

  vga_rect_fill dut (
    .CLK(CLK), .RST_N(RST_N), .IO_WR(IO_WR), .IO_ADDR(IO_ADDR),
    .IO_DATA(IO_DATA), .IO_RD(IO_RD), .FB_WA(FB_WA), .FB_WD(FB_WD),
    .FB_WE(FB_WE), .FB_BUSY(FB_BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mk_wa(input int x, input int y);
    return (y << 8) | x;
  endfunction

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    IO_WR = 1'b1; IO_ADDR = a; IO_DATA = d;
    @(posedge CLK); #1;
    IO_WR = 1'b0;
  endtask

  // Starts on cycle 1 after the COLOR write; stops in the DONE cycle.
  task automatic capture(input int max_cyc, input int mode);
    wa_log.delete(); wd_log.delete();
    done_cyc = 0; busy_cnt = 0; first_we = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (mode == 1) begin
        if (c == 10) begin IO_WR = 1'b1; IO_ADDR = BASE; IO_DATA = 32'h0; end
        else if (c == 11) begin IO_WR = 1'b1; IO_ADDR = BASE + 32'h8; IO_DATA = 32'hFFF; end
        else if (c == 12) begin IO_WR = 1'b0; IO_ADDR = BASE + 32'hC; end
      end
      #3;
      if (mode == 1 && c == 12) rd_busy = IO_RD;
      if (FB_WE) begin
        if (first_we == 0) first_we = c;
        wa_log.push_back(int'(FB_WA));
        wd_log.push_back(int'(FB_WD));
      end
      if (FB_BUSY) busy_cnt++;
      if (DONE) begin
        done_cyc = c;
        rd_done  = IO_RD;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic verify_log(input string tag, input int wd_exp);
    chk({tag, "_count"}, wa_log.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wa_log[i], exp_wa[i]);
      chk($sformatf("%s_wd%0d", tag, i), wd_log[i], wd_exp);
    end
  endtask

  initial begin
    int bad_wa, bad_wd, stray;
    RST_N = 1'b0; IO_WR = 1'b0; IO_ADDR = BASE + 32'hC; IO_DATA = 32'h0;
    #3;
    chk("rst_we", FB_WE, 0);
    chk("rst_busy", FB_BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_wa", FB_WA, 0);
    chk("rst_wd", FB_WD, 0);
    chk("rst_rd", IO_RD, 0);
    #20 RST_N = 1'b1;

    // Solid 3x2 at (10,5)
    io_write(BASE, (5 << 16) | 10);
    io_write(BASE + 32'h4, (2 << 16) | 3);
    io_write(BASE + 32'h8, 32'hF00);
    capture(50, 0);
    exp_wa.delete();
    for (int y = 5; y < 7; y++) for (int x = 10; x < 13; x++) exp_wa.push_back(mk_wa(x, y));
    verify_log("t1", 32'hF00);
    chk("t1_first_we", first_we, 1);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_busy_cnt", busy_cnt, 6);

    // Clipped at the bottom-right corner
    io_write(BASE, (118 << 16) | 158);
    io_write(BASE + 32'h4, (5 << 16) | 5);
    io_write(BASE + 32'h8, 32'h0F0);
    capture(50, 0);
    exp_wa.delete();
    for (int y = 118; y < 120; y++) for (int x = 158; x < 160; x++) exp_wa.push_back(mk_wa(x, y));
    verify_log("t2", 32'h0F0);
    chk("t2_done_cyc", done_cyc, 5);

    // Null fill (w==0); outputs hold the last pixel
    io_write(BASE + 32'h4, (7 << 16) | 0);
    io_write(BASE + 32'h8, 32'h123);
    capture(20, 0);
    chk("t3_writes", wa_log.size(), 0);
    chk("t3_busy_cnt", busy_cnt, 1);
    chk("t3_done_cyc", done_cyc, 2);
    chk("t3_wd_hold", FB_WD, 32'h0F0);
    chk("t3_wa_hold", FB_WA, mk_wa(159, 119));

    // 40x40 fill with ignored mid-fill writes and busy readback
    io_write(BASE, (10 << 16) | 20);
    io_write(BASE + 32'h4, (40 << 16) | 40);
    io_write(BASE + 32'h8, 32'h5A5);
    capture(2000, 1);
    chk("t4_count", wa_log.size(), 1600);
    bad_wa = 0; bad_wd = 0;
    for (int i = 0; i < wa_log.size(); i++) begin
      if (wa_log[i] != mk_wa(20 + i % 40, 10 + i / 40)) bad_wa++;
      if (wd_log[i] != 32'h5A5) bad_wd++;
    end
    chk("t4_bad_wa", bad_wa, 0);
    chk("t4_bad_wd", bad_wd, 0);
    chk("t4_done_cyc", done_cyc, 1601);
    chk("t4_rd_busy", rd_busy, 1);
    chk("t4_rd_done", rd_done, 0);

    // Async reset at cycle 17 of a 100-pixel fill
    io_write(BASE, 32'h0);
    io_write(BASE + 32'h4, (1 << 16) | 100);
    io_write(BASE + 32'h8, 32'h777);
    repeat (16) begin @(posedge CLK); #1; end
    chk("t5_we_before", FB_WE, 1);
    chk("t5_wa_before", FB_WA, mk_wa(16, 0));
    RST_N = 1'b0;
    #1;
    chk("t5_we_rst", FB_WE, 0);
    chk("t5_busy_rst", FB_BUSY, 0);
    chk("t5_done_rst", DONE, 0);
    chk("t5_wa_rst", FB_WA, 0);
    #10 RST_N = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      if (FB_WE || FB_BUSY || DONE) stray++;
    end
    chk("t5_after_rst", stray, 0);

    // Outline 4x3 at origin; bit 12 ignored without the feature
    io_write(BASE, 32'h0);
    io_write(BASE + 32'h4, (3 << 16) | 4);
    io_write(BASE + 32'h8, 32'h1ABC);
    capture(50, 0);
    exp_wa.delete();
`ifdef RECT_OUTLINE_EN
    for (int x = 0; x < 4; x++) exp_wa.push_back(mk_wa(x, 0));
    exp_wa.push_back(mk_wa(0, 1));
    exp_wa.push_back(mk_wa(3, 1));
    for (int x = 0; x < 4; x++) exp_wa.push_back(mk_wa(x, 2));
`else
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) exp_wa.push_back(mk_wa(x, y));
`endif
    verify_log("t6", 32'hABC);
    chk("t6_done_cyc", done_cyc, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
